// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux scheduler.
// State encoding, channel count and stall-timeout length.
package demux_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int N_CH        = 4;
    localparam int TIMEOUT_CYC = 16;

endpackage

// File: rtl/demux_sched_route.sv
// Enabled 2-to-4 one-hot decode of the held channel select.
// Latency: combinational.
// Backpressure: none; the output is a pure function of sel and en.
module demux_sched_route
    import demux_sched_pkg::*;
(
    input  logic [1:0]      sel,
    input  logic            en,
    output logic [N_CH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_sched.sv
// One-word demux to 4 channels, round-robin or fixed; optional stall drop (DEMUX_SCHED_TIMEOUT_EN).
// Latency: a word accepted at edge N is presented from cycle N+1.
// Backpressure: in_ready follows out_ready of the held channel, giving one word per cycle.
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    input  logic            mode,
    input  logic [1:0]      sel,
    output logic [N_CH-1:0] out_valid,
    output logic [W-1:0]    out_data,
    input  logic [N_CH-1:0] out_ready,
    output logic [1:0]      cur_sel,
    output logic            drop
);

    state_t         state_q, state_d;
    logic [1:0]     rr_q, rr_d;
    logic [1:0]     cur_sel_q, cur_sel_d;
    logic [W-1:0]   held_dat_q, held_dat_d;
    logic           xfer;
    logic           accept;
    logic           timeout;

    assign xfer     = (state_q == SEND) && out_ready[cur_sel_q];
    assign in_ready = !rst && ((state_q == IDLE) || out_ready[cur_sel_q]);
    assign accept   = in_valid && in_ready;

`ifdef DEMUX_SCHED_TIMEOUT_EN
    logic [3:0] to_cnt_q, to_cnt_d;

    // to_cnt_q holds the number of stalled cycles already seen in this SEND.
    assign timeout = (state_q == SEND) && !xfer && (to_cnt_q == 4'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q + 4'd1;
        if (accept || xfer || timeout || (state_q != SEND)) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign drop = timeout && !rst;

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        held_dat_d = held_dat_q;
        rr_d       = rr_q;
        // Advance before computing a coincident acceptance target.
        if ((xfer || timeout) && !mode) begin
            rr_d = rr_q + 2'd1;
        end
        if (accept) begin
            state_d    = SEND;
            held_dat_d = in_data;
            cur_sel_d  = mode ? sel : rr_d;
        end else if (xfer || timeout) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cur_sel_q  <= '0;
            held_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_sel_q  <= cur_sel_d;
            held_dat_q <= held_dat_d;
        end
    end

    demux_sched_route u_route (
        .sel    (cur_sel_q),
        .en     (state_q == SEND),
        .onehot (out_valid)
    );

    assign out_data = held_dat_q;
    assign cur_sel  = cur_sel_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched: routing, backpressure, stall timeout and reset.
module tb_demux_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   out_ready;
    logic [1:0]   cur_sel;
    logic         drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_sched #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .drop      (drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] words [4];
    logic [3:0]   exp_vld [4];

    initial begin
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
        exp_vld[0] = 4'b0001; exp_vld[1] = 4'b0010; exp_vld[2] = 4'b0100; exp_vld[3] = 4'b1000;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; sel = 2'd0; out_ready = 4'hF;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_drop", drop, 0);
        check("rst_cur_sel", cur_sel, 0);
        check("rst_out_data", out_data, 0);

        // Round-robin, back-to-back words A..D
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            check($sformatf("rr_vld_%0d", i), out_valid, exp_vld[i]);
            check($sformatf("rr_dat_%0d", i), out_data, words[i]);
            check($sformatf("rr_rdy_%0d", i), in_ready, 1);
        end

        // rr_ptr wraps 3 -> 0 on the transfer of D
        in_data = 8'hE5;
        tick();
        check("wrap_vld", out_valid, 4'b0001);
        check("wrap_sel", cur_sel, 0);
        check("wrap_dat", out_data, 8'hE5);
        in_valid = 1'b0;
        tick();
        check("rr_idle_vld", out_valid, 0);
        check("rr_idle_rdy", in_ready, 1);

        // Fixed routing to channel 2 with 3 stall cycles
        mode = 1'b1; sel = 2'd2; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0; sel = 2'd1; out_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_vld_%0d", i), out_valid, 4'b0100);
            check($sformatf("hold_dat_%0d", i), out_data, 8'h5A);
            check($sformatf("hold_rdy_%0d", i), in_ready, 0);
            check($sformatf("hold_sel_%0d", i), cur_sel, 2);
            tick();
        end
        out_ready = 4'hF;
        #1;
        check("hold_last_vld", out_valid, 4'b0100);
        check("hold_last_rdy", in_ready, 1);
        tick();
        check("hold_done_vld", out_valid, 0);

        // Stall with out_ready low; rr_ptr is 1 here
        mode = 1'b0; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        check("stall_vld", out_valid, 4'b0010);
`ifdef DEMUX_SCHED_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            check($sformatf("stall_nodrop_%0d", i), drop, 0);
            tick();
        end
        check("to_drop", drop, 1);
        check("to_drop_vld", out_valid, 4'b0010);
        tick();
        check("to_idle_vld", out_valid, 0);
        check("to_idle_rdy", in_ready, 1);
        check("to_idle_drop", drop, 0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("wait_vld", out_valid, 4'b0010);
        check("wait_dat", out_data, 8'h77);
        check("wait_drop", drop, 0);
        check("wait_rdy", in_ready, 0);
        out_ready = 4'hF;
        tick();
        check("wait_idle_vld", out_valid, 0);
        out_ready = 4'h0;
`endif

        // Reset while holding a word on channel 1
        mode = 1'b1; sel = 2'd1; in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        check("pre_rst_vld", out_valid, 4'b0010);
        rst = 1'b1;
        tick();
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_rdy", in_ready, 0);
        check("mid_rst_drop", drop, 0);
        check("mid_rst_dat", out_data, 0);
        rst = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 4'hF;
        #1;
        check("post_rst_rdy", in_ready, 1);
        tick();
        check("post_rst_vld", out_valid, 4'b0001);
        check("post_rst_sel", cur_sel, 0);
        check("post_rst_dat", out_data, 8'h11);
        in_valid = 1'b0;
        tick();
        check("end_idle_vld", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
